// File: rtl/fpacc_pkg.sv
// rtl/fpacc_pkg.sv - shared field widths, FP word layout and state encoding for fpacc
package fpacc_pkg;

  localparam int EXPW = 11;
  localparam int FRW  = 52;
  localparam int MW   = 56;
  localparam int BIAS = 1023;

  typedef struct packed {
    logic            sign;
    logic [EXPW-1:0] exp;
    logic [FRW-1:0]  frac;
  } fp_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/fpacc_if.sv
// rtl/fpacc_if.sv - product-term input stream and completed-sum output of fpacc
interface fpacc_if #(parameter int CNTW = 16);
  logic            pushin;
  logic            first;
  logic            last;
  logic [63:0]     a;
  logic            pushout;
  logic [63:0]     r;
  logic [CNTW-1:0] cnt;

  modport master (output pushin, first, last, a, input pushout, r, cnt);
  modport slave  (input pushin, first, last, a, output pushout, r, cnt);
endinterface

// File: rtl/fpadd_core.sv
// rtl/fpadd_core.sv - combinational add of two reduced-format FP words
// Align, add/subtract, normalize, round half away from zero; zero operands pass through.
module fpadd_core
  import fpacc_pkg::*;
(
  input  fp_t x,
  input  fp_t y,
  output fp_t z
);

  fp_t            l, s;
  logic [EXPW-1:0] d, e;
  logic [MW-1:0]  ml, ms, ms_sh, mask, diff, m;
  logic [MW:0]    sum, rnd;
  logic [5:0]     lz;
  logic           xz, yz, dz;

  always_comb begin
    xz = ({x.exp, x.frac} == '0);
    yz = ({y.exp, y.frac} == '0);
    if ({x.exp, x.frac} >= {y.exp, y.frac}) begin
      l = x;
      s = y;
    end else begin
      l = y;
      s = x;
    end
    ml   = {1'b1, l.frac, 3'b000};
    ms   = {1'b1, s.frac, 3'b000};
    d    = l.exp - s.exp;
    mask = '0;
    // Anything shifted fully past the guard bits survives only as sticky.
    if (d >= EXPW'(MW)) begin
      ms_sh = MW'(1);
    end else begin
      mask  = (MW'(1) << d[5:0]) - MW'(1);
      ms_sh = (ms >> d[5:0]) | MW'(|(ms & mask));
    end
    e    = l.exp;
    sum  = '0;
    diff = '0;
    lz   = '0;
    dz   = 1'b0;
    if (l.sign == s.sign) begin
      sum = {1'b0, ml} + {1'b0, ms_sh};
      if (sum[MW]) begin
        m = sum[MW:1] | MW'(sum[0]);
        e = e + 1'b1;
      end else begin
        m = sum[MW-1:0];
      end
    end else begin
      diff = ml - ms_sh;
      dz   = (diff == '0);
      for (int i = 0; i < MW; i++) begin
        if (diff[i]) lz = 6'(MW - 1 - i);
      end
      m = diff << lz;
      e = e - EXPW'(lz);
    end
    rnd = {1'b0, m} + {53'd0, m[2], 3'b000};
    if (rnd[MW]) begin
      m = rnd[MW:1];
      e = e + 1'b1;
    end else begin
      m = rnd[MW-1:0];
    end
    if (xz && yz)  z = '0;
    else if (xz)   z = y;
    else if (yz)   z = x;
    else if (dz)   z = '0;
    else           z = '{sign: l.sign, exp: e, frac: m[MW-2:3]};
  end

endmodule

// File: rtl/fpacc.sv
// rtl/fpacc.sv - framed floating-point accumulator behind the triple-product multiplier
// Holds the frame state, running sum, term counter and registered result.
module fpacc
  import fpacc_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic    clk,
  input  logic    rst,
  fpacc_if.slave  io
);

  state_e          state_q, state_d;
  fp_t             acc_q, acc_d, r_q, r_d, a_in, sum;
  logic [CNTW-1:0] run_q, run_d, cnt_q, cnt_d;
  logic            pushout_q, pushout_d;
  logic            start;

  assign a_in = io.a;

  fpadd_core u_add (
    .x (acc_q),
    .y (a_in),
    .z (sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    run_d     = run_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    pushout_d = 1'b0;
    start     = io.first || (state_q == IDLE);
    if (io.pushin) begin
      // A lone zero term must still come out as canonical +0.
      if (start) acc_d = ({a_in.exp, a_in.frac} == '0) ? '0 : a_in;
      else       acc_d = sum;
      if (start)       run_d = CNTW'(1);
      else if (&run_q) run_d = run_q;
      else             run_d = run_q + 1'b1;
      if (io.last) begin
        r_d       = acc_d;
        cnt_d     = run_d;
        pushout_d = 1'b1;
        state_d   = IDLE;
      end else begin
        state_d   = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      run_q     <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      pushout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      run_q     <= run_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      pushout_q <= pushout_d;
    end
  end

  assign io.pushout = pushout_q;
  assign io.r       = r_q;
  assign io.cnt     = cnt_q;

endmodule

// File: tb/tb_fpacc.sv
// tb/tb_fpacc.sv - directed self-checking bench for fpacc
module tb_fpacc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpacc_if #(.CNTW(16)) io ();
  fpacc_if #(.CNTW(2))  io2 ();

  fpacc #(.CNTW(16)) dut  (.clk(clk), .rst(rst), .io(io));
  fpacc #(.CNTW(2))  dut2 (.clk(clk), .rst(rst), .io(io2));

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;

  always @(negedge clk) if (io.pushout === 1'b1) pulses++;

  task automatic send(input logic f, input logic l, input logic [63:0] v);
    @(negedge clk);
    io.pushin = 1'b1; io.first = f; io.last = l; io.a = v;
  endtask

  task automatic idle();
    @(negedge clk);
    io.pushin = 1'b0; io.first = 1'b0; io.last = 1'b0; io.a = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      io.pushin = 1'($urandom); io.first = 1'($urandom); io.last = 1'($urandom);
      io.a = {$urandom, $urandom};
      #1;
      compared++; if (io.pushout !== 1'b0) begin mismatched++; $display("FAIL reset_pushout: got %b want 0", io.pushout); end
      compared++; if (io.r !== 64'h0) begin mismatched++; $display("FAIL reset_r: got %h want 0", io.r); end
      compared++; if (io.cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", io.cnt); end
    end
    idle();
    rst = 1'b1;
    idle();
  endtask

  task automatic test_single();
    send(1, 1, 64'h3FF8000000000000);
    idle();
    compared++; if (io.pushout !== 1'b1) begin mismatched++; $display("FAIL single_pushout: got %b want 1", io.pushout); end
    compared++; if (io.r !== 64'h3FF8000000000000) begin mismatched++; $display("FAIL single_r: got %h want 3ff8000000000000", io.r); end
    compared++; if (io.cnt !== 16'd1) begin mismatched++; $display("FAIL single_cnt: got %0d want 1", io.cnt); end
    idle();
    compared++; if (io.pushout !== 1'b0) begin mismatched++; $display("FAIL single_pulse_width: got %b want 0", io.pushout); end
    compared++; if (io.r !== 64'h3FF8000000000000) begin mismatched++; $display("FAIL single_r_hold: got %h want 3ff8000000000000", io.r); end
  endtask

  task automatic test_cancel();
    send(1, 0, 64'h3FF0000000000000);
    send(0, 0, 64'h4000000000000000);
    send(0, 1, 64'hC008000000000000);
    idle();
    compared++; if (io.pushout !== 1'b1) begin mismatched++; $display("FAIL cancel_pushout: got %b want 1", io.pushout); end
    compared++; if (io.r !== 64'h0) begin mismatched++; $display("FAIL cancel_r: got %h want 0", io.r); end
    compared++; if (io.cnt !== 16'd3) begin mismatched++; $display("FAIL cancel_cnt: got %0d want 3", io.cnt); end
    send(1, 0, 64'h3FF0000000000000);
    send(0, 1, 64'h4000000000000000);
    idle();
    compared++; if (io.r !== 64'h4008000000000000) begin mismatched++; $display("FAIL add_1_2_r: got %h want 4008000000000000", io.r); end
    compared++; if (io.cnt !== 16'd2) begin mismatched++; $display("FAIL add_1_2_cnt: got %0d want 2", io.cnt); end
  endtask

  task automatic test_round();
    send(1, 0, 64'h3FF0000000000000);
    send(0, 1, 64'h3CA0000000000000);
    idle();
    compared++; if (io.r !== 64'h3FF0000000000001) begin mismatched++; $display("FAIL round_half_r: got %h want 3ff0000000000001", io.r); end
    send(1, 0, 64'h3FF0000000000000);
    send(0, 1, 64'h3C30000000000000);
    idle();
    compared++; if (io.r !== 64'h3FF0000000000000) begin mismatched++; $display("FAIL sticky_r: got %h want 3ff0000000000000", io.r); end
  endtask

  task automatic test_misc();
    // Non-first beat in IDLE opens a frame; 1.0 - 0.5 needs left-normalization.
    send(0, 0, 64'h3FF0000000000000);
    send(0, 1, 64'hBFE0000000000000);
    idle();
    compared++; if (io.r !== 64'h3FE0000000000000) begin mismatched++; $display("FAIL norm_r: got %h want 3fe0000000000000", io.r); end
    compared++; if (io.cnt !== 16'd2) begin mismatched++; $display("FAIL norm_cnt: got %0d want 2", io.cnt); end
    send(1, 0, 64'hBFF0000000000000);
    send(0, 1, 64'hC000000000000000);
    idle();
    compared++; if (io.r !== 64'hC008000000000000) begin mismatched++; $display("FAIL neg_sum_r: got %h want c008000000000000", io.r); end
    send(1, 0, 64'h4000000000000000);
    send(1, 1, 64'h3FF0000000000000);
    idle();
    compared++; if (io.r !== 64'h3FF0000000000000) begin mismatched++; $display("FAIL restart_r: got %h want 3ff0000000000000", io.r); end
    compared++; if (io.cnt !== 16'd1) begin mismatched++; $display("FAIL restart_cnt: got %0d want 1", io.cnt); end
    send(1, 0, 64'h8000000000000000);
    send(0, 1, 64'h3FF0000000000000);
    idle();
    compared++; if (io.r !== 64'h3FF0000000000000) begin mismatched++; $display("FAIL zero_term_r: got %h want 3ff0000000000000", io.r); end
    send(1, 1, 64'h8000000000000000);
    idle();
    compared++; if (io.r !== 64'h0) begin mismatched++; $display("FAIL neg_zero_r: got %h want 0", io.r); end
  endtask

  task automatic test_back_to_back();
    send(1, 1, 64'h4000000000000000);
    send(1, 0, 64'h3FE0000000000000);
    compared++; if (io.pushout !== 1'b1) begin mismatched++; $display("FAIL b2b_p1: got %b want 1", io.pushout); end
    compared++; if (io.r !== 64'h4000000000000000) begin mismatched++; $display("FAIL b2b_r1: got %h want 4000000000000000", io.r); end
    send(0, 1, 64'h3FE0000000000000);
    compared++; if (io.pushout !== 1'b0) begin mismatched++; $display("FAIL b2b_gap: got %b want 0", io.pushout); end
    send(1, 1, 64'h3FF8000000000000);
    compared++; if (io.pushout !== 1'b1) begin mismatched++; $display("FAIL b2b_p2: got %b want 1", io.pushout); end
    compared++; if (io.r !== 64'h3FF0000000000000) begin mismatched++; $display("FAIL b2b_r2: got %h want 3ff0000000000000", io.r); end
    compared++; if (io.cnt !== 16'd2) begin mismatched++; $display("FAIL b2b_cnt2: got %0d want 2", io.cnt); end
    idle();
    compared++; if (io.pushout !== 1'b1) begin mismatched++; $display("FAIL b2b_p3: got %b want 1", io.pushout); end
    compared++; if (io.r !== 64'h3FF8000000000000) begin mismatched++; $display("FAIL b2b_r3: got %h want 3ff8000000000000", io.r); end
  endtask

  task automatic test_reset_mid();
    idle();
    idle();
    pulses = 0;
    send(1, 0, 64'h3FF0000000000000);
    @(negedge clk);
    io.pushin = 1'b0; io.first = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    send(1, 1, 64'h4000000000000000);
    idle();
    compared++; if (io.r !== 64'h4000000000000000) begin mismatched++; $display("FAIL midrst_r: got %h want 4000000000000000", io.r); end
    compared++; if (io.cnt !== 16'd1) begin mismatched++; $display("FAIL midrst_cnt: got %0d want 1", io.cnt); end
    idle();
    idle();
    compared++; if (pulses !== 1) begin mismatched++; $display("FAIL midrst_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io2.pushin = 1'b1; io2.first = (i == 0); io2.last = (i == 4);
      io2.a = 64'h3FF0000000000000;
    end
    @(negedge clk);
    io2.pushin = 1'b0; io2.first = 1'b0; io2.last = 1'b0;
    compared++; if (io2.pushout !== 1'b1) begin mismatched++; $display("FAIL sat_pushout: got %b want 1", io2.pushout); end
    compared++; if (io2.r !== 64'h4014000000000000) begin mismatched++; $display("FAIL sat_r: got %h want 4014000000000000", io2.r); end
    compared++; if (io2.cnt !== 2'd3) begin mismatched++; $display("FAIL sat_cnt: got %0d want 3", io2.cnt); end
  endtask

  initial begin
    io.pushin = 1'b0; io.first = 1'b0; io.last = 1'b0; io.a = '0;
    io2.pushin = 1'b0; io2.first = 1'b0; io2.last = 1'b0; io2.a = '0;
    test_reset();
    test_single();
    test_cancel();
    test_round();
    test_misc();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fpacc.md
# fpacc

Floating-point accumulator placed directly downstream of the triple-product multiplier. It consumes the multiplier's `pushout`/`r` stream and sums a framed sequence of products (`first` … `last`) into one result. It uses the same reduced 64-bit format: sign in bit 63, exponent in bits 62:52, fraction in bits 51:0 with a hidden 1, and no NaN, infinity, overflow or underflow handling. The finished sum is emitted with a one-cycle `pushout` pulse, making this the dot-product back end of the datapath.

## Interface
- `CNTW`, default 16: width of the term counter.
- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `pushin`, input, 1: `a`, `first` and `last` are valid this cycle. There is no backpressure.
- `first`, input, 1: this beat starts a new sum.
- `last`, input, 1: this beat closes the sum.
- `a`, input, 64: the incoming product term.
- `pushout`, output, 1: single-cycle pulse; `r` and `cnt` carry a completed sum.
- `r`, output, 64: the completed sum.
- `cnt`, output, CNTW: number of terms in `r`, saturating at 2^CNTW-1.

## Operation
- **States**
  - IDLE: no open sum.
  - ACC: sum open.
- **Beat handling**
  - `pushin & first`: `acc` is loaded with `a`. This happens in any state and discards any open sum.
  - `pushin & !first` in IDLE: treated as `first`.
  - `pushin & !first` in ACC: `acc` becomes `acc + a`.
  - `pushin & last`: the post-update accumulator value is latched into `r` and the state returns to IDLE. `first & last` together is a single-term sum.
  - `pushin = 1` and `last = 0`: the state goes to ACC.
- **Zero handling**
  - A term is zero when `a[62:0] == 0`; its sign is ignored.
  - A zero result is always canonical +0, i.e. 64'h0.
- **Add rules (X + Y)**
  - Mantissa = {1, fract, 3'b000}, 56 bits, with guard bits [2:0].
  - L is the operand with the larger magnitude, compared by exponent and then fraction. S is the other operand.
  - The result sign is L's sign.
  - S is shifted right by d = eL − eS. Bits shifted out are OR-ed into bit 0 (sticky). If d ≥ 56, S becomes 56'd1.
  - Same signs: the 57-bit sum is formed. On carry-out, shift right by 1 keeping the sticky bit, and add 1 to the exponent.
  - Opposite signs: L − S. A zero difference gives the zero result. Otherwise left-normalize until bit 55 = 1 and subtract the shift count from the exponent.
  - Rounding: if bit 2 = 1, add 1 at bit 3 (round half away from zero). A rounding carry-out renormalizes and adds 1 to the exponent.
  - Result = {sign, exp, m[54:3]}.
- **Exponent arithmetic** is modulo 2^11, with no saturation.
- **`cnt`** counts accepted beats of the current sum. The first beat sets it to 1, and it saturates at 2^CNTW-1.

## Timing
- Throughput: one beat per cycle, sustained indefinitely.
- Add latency: the accumulate is a single-cycle combinational add into the `acc` register.
- Output latency: `pushout` is high in the cycle after the `last` beat, for exactly one cycle.
- `r` and `cnt` hold their values until the next `pushout`.
- Back-to-back frames are supported: a `last` beat followed immediately by a `first` beat gives correct results, with consecutive `pushout` pulses possible.
- Reset values: `pushout` = 0, `r` = 0, `cnt` = 0, `acc` = 0, state = IDLE.
- Reset asserted mid-sum aborts the sum. No `pushout` is produced for the aborted frame.

## Structure
- Package `fpacc_pkg` holds:
  - The field widths (EXPW = 11, FRW = 52, MW = 56) and the bias (1023).
  - Packed struct typedefs for the FP word fields.
  - The state enum.
- Sub-module `fpadd_core` is purely combinational. It implements align, add/subtract, normalize and round, and also handles zero operands. `fpacc` holds only the state machine, `acc`, the counter and the output registers.

## Test plan
- **Reset:** hold `rst` low during random `pushin` activity → `pushout` = 0, `r` = 0, `cnt` = 0 throughout.
- **Single term:** `pushin` with `first` = `last` = 1 and `a` = 64'h3FF8000000000000 → next cycle `pushout` = 1, `r` = 64'h3FF8000000000000, `cnt` = 1.
- **Cancellation:** beats 1.0, 2.0, −3.0 (64'h3FF0…, 64'h4000…, 64'hC008…) with `last` on the third → `r` = 64'h0, `cnt` = 3. The two-beat frame 1.0 + 2.0 → 64'h4008000000000000.
- **Rounding and sticky:**
  - 64'h3FF0000000000000 + 64'h3CA0000000000000 → 64'h3FF0000000000001.
  - 64'h3FF0000000000000 + 64'h3C30000000000000 → 64'h3FF0000000000000.
- **Back-to-back frames:** frame {2.0} immediately followed by frame {0.5, 0.5} → pulses one cycle after each `last`, with `r` = 64'h4000000000000000 then 64'h3FF0000000000000.
- **Reset mid-sum:** `first` beat 1.0, then a `rst` pulse, then `first` = `last` = 1 with 2.0 → exactly one `pushout`, `r` = 64'h4000000000000000, `cnt` = 1.
